// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC sequencer and fetch initiator for the program-memory region.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] PROG_BASE = 32'h0000_31b0,
   parameter logic [31:0] PROG_LAST = 32'h0000_35af,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        stall_i,
   input  logic        branch_valid_i,
   input  logic [31:0] branch_target_i,
   input  logic        cs_p_i,
   input  logic [31:0] mem_data_i,
   input  logic        mem_valid_i,
   output logic [31:0] address_in_o,
   output logic        fetch_req_o,
   output logic [31:0] pc_out_o,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        fault_o
);

   localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        pc_out_q, pc_out_d;
   logic [31:0]        instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [32:0]        w_pc_end;
   logic               w_pc_legal;

   // 33-bit end address so a PC near the top of the space cannot wrap into range.
   assign w_pc_end   = {1'b0, pc_q} + 33'd3;
   assign w_pc_legal = (pc_q >= PROG_BASE) && (w_pc_end <= {1'b0, PROG_LAST})
                       && (pc_q[1:0] == 2'b00);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pc_out_d      = pc_out_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      timer_d       = timer_q;
      fetch_req_o   = 1'b0;
      if (state_q == S_FAULT) begin
         instr_valid_d = 1'b0;
      end else if (branch_valid_i) begin
         pc_d          = branch_target_i;
         instr_valid_d = 1'b0;
         timer_d       = '0;
         state_d       = S_REQ;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_i) state_d = S_REQ;
            end
            S_REQ: begin
               timer_d = '0;
               if (!w_pc_legal) begin
                  state_d = S_FAULT;
               end else begin
                  fetch_req_o = 1'b1;
                  state_d     = S_WAIT;
               end
            end
            S_WAIT: begin
               // cs_p reflects the address presented a cycle earlier by the decoder.
               if (!cs_p_i) begin
                  state_d = S_FAULT;
               end else if (mem_valid_i) begin
                  instr_d       = mem_data_i;
                  pc_out_d      = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + 32'd4;
                  timer_d       = '0;
                  state_d       = S_HOLD;
               end else if (timer_q == TIMER_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  instr_valid_d = 1'b0;
                  state_d       = en_i ? S_REQ : S_IDLE;
               end
            end
            default: state_d = S_FAULT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= PROG_BASE;
         pc_out_q      <= PROG_BASE;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pc_out_q      <= pc_out_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         timer_q       <= timer_d;
      end
   end

   assign address_in_o  = pc_q;
   assign pc_out_o      = pc_out_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign fault_o       = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] BASE = 32'h0000_31b0;
   localparam logic [31:0] LAST = 32'h0000_35af;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        en        = 1'b0;
   logic        stall     = 1'b0;
   logic        br_v      = 1'b0;
   logic [31:0] br_t      = '0;
   logic        cs_p;
   logic [31:0] mem_data  = '0;
   logic        mem_valid = 1'b0;
   logic [31:0] address_in;
   logic        fetch_req;
   logic [31:0] pc_out;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fault;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .PROG_BASE (BASE),
      .PROG_LAST (LAST),
      .TIMEOUT   (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en_i            (en),
      .stall_i         (stall),
      .branch_valid_i  (br_v),
      .branch_target_i (br_t),
      .cs_p_i          (cs_p),
      .mem_data_i      (mem_data),
      .mem_valid_i     (mem_valid),
      .address_in_o    (address_in),
      .fetch_req_o     (fetch_req),
      .pc_out_o        (pc_out),
      .instr_o         (instr),
      .instr_valid_o   (instr_valid),
      .fault_o         (fault)
   );

   // Registered address decoder for the program region.
   logic cs_reg    = 1'b0;
   bit   cs_force0 = 1'b0;
   always @(posedge clk) cs_reg <= (address_in >= BASE) && (address_in <= LAST);
   assign cs_p = cs_reg & ~cs_force0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   int          n_vec = 0, n_err = 0, n_xfer = 0, n_strobe = 0;
   exp_t        sb_q[$];
   logic [31:0] salt = '0;
   logic [31:0] m_pc = BASE;        // next program address the model expects fetched
   logic [31:0] resp_addr = '0, stale_data = '0, last_strobe = '0, hold_pc = '0;
   bit          live = 1'b0, stale_pend = 1'b0;
   int          resp_cnt = 0, lat_min = 1, lat_max = 1, hold_left = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   function automatic void chk1(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endfunction

   // One clock of stimulus plus the memory responder and the reference model.
   task automatic step(input bit s, input bit b, input logic [31:0] t, input bit e);
      bit   s_eff, in_hold, delivering, legal;
      exp_t x;
      @(negedge clk);
      s_eff   = s;
      in_hold = 1'b0;
      if (hold_left > 0 && instr_valid && pc_out == hold_pc) begin
         s_eff   = 1'b1;
         in_hold = 1'b1;
         hold_left--;
      end
      en = e; stall = s_eff; br_v = b; br_t = t;
      mem_valid  = 1'b0;
      mem_data   = $urandom;
      delivering = 1'b0;
      if (stale_pend) begin
         mem_valid  = 1'b1;
         mem_data   = stale_data;
         stale_pend = 1'b0;
      end
      if (live) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            delivering = 1'b1;
            mem_valid  = 1'b1;
            mem_data   = resp_addr ^ salt;
         end
      end
      if (b) begin
         // A redirect drops whatever the decode stage has not yet taken.
         sb_q.delete();
         if (live && !delivering) begin
            stale_pend = 1'b1;
            stale_data = resp_addr ^ salt;
         end
         live = 1'b0;
         m_pc = t;
      end else if (delivering) begin
         x.pc   = m_pc;
         x.data = m_pc ^ salt;
         sb_q.push_back(x);
         m_pc = m_pc + 32'd4;
         live = 1'b0;
      end
      #1;
      if (in_hold) begin
         chk("stall_pc_out", pc_out, hold_pc);
         chk("stall_instr", instr, hold_pc ^ salt);
         chk1("stall_valid", instr_valid, 1'b1);
         chk1("stall_no_strobe", fetch_req, 1'b0);
      end
      if (fetch_req) begin
         legal = (m_pc >= BASE) && (m_pc <= LAST - 32'd3) && (m_pc[1:0] == 2'b00);
         chk("strobe_addr", address_in, m_pc);
         chk1("strobe_legal", legal, 1'b1);
         live        = 1'b1;
         resp_cnt    = $urandom_range(lat_max, lat_min);
         resp_addr   = address_in;
         last_strobe = address_in;
         n_strobe++;
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      live        = 1'b0;
      stale_pend  = 1'b0;
      m_pc        = BASE;
      hold_left   = 0;
      cs_force0   = 1'b0;
      last_strobe = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; stall = 1'b0; br_v = 1'b0; mem_valid = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every accepted instruction is matched against the scoreboard.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && instr_valid && !stall && !br_v) begin
            if (sb_q.size() == 0) begin
               chk1("spurious_instr_valid", instr_valid, 1'b0);
            end else begin
               x = sb_q.pop_front();
               chk("xfer_pc_out", pc_out, x.pc);
               chk("xfer_instr", instr, x.data);
               n_xfer++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      bit b;
      logic [31:0] t;

      // Reset state, then asynchronous reset while waiting on a fetch.
      do_reset();
      #1;
      chk("rst_pc_out", pc_out, BASE);
      chk("rst_address_in", address_in, BASE);
      chk("rst_instr", instr, 32'h0);
      chk1("rst_instr_valid", instr_valid, 1'b0);
      chk1("rst_fault", fault, 1'b0);
      chk1("rst_fetch_req", fetch_req, 1'b0);
      lat_min = 1000; lat_max = 1000;
      step(0, 1, 32'h0000_3200, 1);
      step(0, 0, 32'h0, 1);
      chk("t1_strobe_addr", last_strobe, 32'h0000_3200);
      step(0, 0, 32'h0, 1);
      #2 rst = 1'b1;
      #1;
      chk("t1_async_address_in", address_in, BASE);
      chk("t1_async_pc_out", pc_out, BASE);
      chk1("t1_async_valid", instr_valid, 1'b0);
      chk1("t1_async_fault", fault, 1'b0);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      model_clear();
      s0 = n_strobe;
      step(0, 0, 32'h0, 0);
      step(0, 0, 32'h0, 0);
      chk("t1_idle_no_strobe", 32'(n_strobe - s0), 32'd0);
      chk1("t1_idle_fault", fault, 1'b0);

      // Sequential sweep of the whole region, ending in a range fault.
      do_reset();
      salt = '0; lat_min = 1; lat_max = 1; n_xfer = 0;
      for (int i = 0; i < 1000 && !fault; i++) step(0, 0, 32'h0, 1);
      chk1("sweep_fault", fault, 1'b1);
      chk("sweep_words", 32'(n_xfer), 32'd256);
      chk("sweep_last_pc_out", pc_out, 32'h0000_35ac);
      chk("sweep_last_instr", instr, 32'h0000_35ac);
      chk("sweep_fault_pc", address_in, 32'h0000_35b0);
      chk1("sweep_valid_low", instr_valid, 1'b0);

      // Stall for five cycles while the word at 0x31b4 is held.
      do_reset();
      salt = '0; lat_min = 1; lat_max = 1;
      hold_pc = 32'h0000_31b4; hold_left = 5;
      for (int i = 0; i < 60 && last_strobe != 32'h0000_31b8; i++) step(0, 0, 32'h0, 1);
      chk("stall_cycles_left", 32'(hold_left), 32'd0);
      chk("stall_next_fetch", last_strobe, 32'h0000_31b8);

      // Redirect while waiting for 0x31c0; the stale response must be dropped.
      do_reset();
      salt = '0; lat_min = 3; lat_max = 3;
      for (int i = 0; i < 200 && last_strobe != 32'h0000_31c0; i++) step(0, 0, 32'h0, 1);
      chk("br_wait_strobe", last_strobe, 32'h0000_31c0);
      step(0, 0, 32'h0, 1);
      step(0, 1, 32'h0000_3400, 1);
      for (int i = 0; i < 30 && !instr_valid; i++) step(0, 0, 32'h0, 1);
      chk1("br_first_valid", instr_valid, 1'b1);
      chk("br_first_pc_out", pc_out, 32'h0000_3400);
      chk("br_first_instr", instr, 32'h0000_3400);

      // Misaligned redirect target.
      do_reset();
      lat_min = 1; lat_max = 1;
      step(0, 1, 32'h0000_3402, 1);
      step(0, 0, 32'h0, 1);
      chk1("misalign_fault_1clk", fault, 1'b0);
      step(0, 0, 32'h0, 1);
      chk1("misalign_fault_2clk", fault, 1'b1);
      chk1("misalign_valid", instr_valid, 1'b0);

      // Chip select withheld during WAIT.
      do_reset();
      cs_force0 = 1'b1; lat_min = 1000; lat_max = 1000;
      s0 = n_strobe;
      for (int i = 0; i < 10 && n_strobe == s0; i++) step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      chk1("cs_fault_early", fault, 1'b0);
      step(0, 0, 32'h0, 1);
      chk1("cs_fault", fault, 1'b1);

      // Memory never answers: timeout after eight WAIT cycles.
      do_reset();
      lat_min = 1000; lat_max = 1000;
      s0 = n_strobe;
      for (int i = 0; i < 10 && n_strobe == s0; i++) step(0, 0, 32'h0, 1);
      chk("tmo_strobe_addr", last_strobe, BASE);
      repeat (8) step(0, 0, 32'h0, 1);
      chk1("tmo_fault_7clk", fault, 1'b0);
      step(0, 0, 32'h0, 1);
      chk1("tmo_fault_8clk", fault, 1'b1);
      step(0, 0, 32'h0, 1);
      chk1("tmo_fault_sticky", fault, 1'b1);
      chk1("tmo_fault_no_strobe", fetch_req, 1'b0);

      // Randomised traffic: stalls, enable toggling, redirects, variable latency.
      do_reset();
      salt = $urandom; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 1500; i++) begin
         b = ($urandom_range(99, 0) < 5) || (m_pc >= BASE + 32'h0000_03c0);
         t = BASE + 32'($urandom_range(127, 0) * 4);
         step($urandom_range(99, 0) < 30, b, t, $urandom_range(99, 0) < 85);
      end
      chk1("rand_no_fault", fault, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
